// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 memory responder.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/picorv32_mem_responder_if.sv
// picorv32 native memory bus: master drives the request, slave returns ready/rdata.
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_lfsr.sv
// Free-running 16-bit Galois LFSR supplying 0..3 extra wait cycles.
// Only compiled when MEM_RESPONDER_JITTER_EN is defined.
`ifdef MEM_RESPONDER_JITTER_EN
module picorv32_mem_lfsr
    import picorv32_mem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic [1:0] jitter_o
);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign jitter_o = lfsr_q[1:0];
endmodule
`endif

// File: rtl/picorv32_mem_responder.sv
// Word-RAM slave for the picorv32 native memory interface with programmable wait states.
// Optional random extra latency when MEM_RESPONDER_JITTER_EN is defined.
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] OOB_RDATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    picorv32_mem_responder_if.slave   mem,
    output logic                      busy,
    output logic                      err_oob,
    output logic                      err_abort,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [4:0]  LAT = 5'(LATENCY);

    state_e      state_q, state_d;
    mem_req_t    req_q, req_d, cur;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_oob_q, err_oob_d, err_abort_q, err_abort_d;
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [31:0] ram [DEPTH];

    logic [1:0]    jitter;
    logic [4:0]    wait_len;
    logic [31:0]   offset;
    logic          borrow;
    logic          oob;
    logic [AW-1:0] word;
    logic          unused_bits;

`ifdef MEM_RESPONDER_JITTER_EN
    picorv32_mem_lfsr u_lfsr (
        .clk      (clk),
        .resetn   (resetn),
        .jitter_o (jitter)
    );
`else
    assign jitter = 2'b00;
`endif

    assign wait_len = LAT + {3'b000, jitter};

    // In IDLE the live bus is decoded so LATENCY=0 can preload read data; otherwise the captured request.
    always_comb begin
        cur = req_q;
        if (state_q == IDLE) begin
            cur = '{instr: mem.mem_instr, addr: mem.mem_addr,
                    wdata: mem.mem_wdata, wstrb: mem.mem_wstrb};
        end
    end

    assign {borrow, offset} = {1'b0, cur.addr} - {1'b0, BASE_ADDR};
    assign word             = offset[AW+1:2];
    assign oob              = borrow || (offset[31:AW+2] != '0);
    assign unused_bits      = ^{req_q.instr, offset[1:0]};

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_oob_d   = err_oob_q;
        err_abort_d = err_abort_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        case (state_q)
            IDLE: begin
                if (mem.mem_valid) begin
                    req_d   = cur;
                    cnt_d   = wait_len;
                    state_d = (wait_len == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!mem.mem_valid) begin
                    state_d     = IDLE;
                    err_abort_d = 1'b1;
                end else if (cnt_q == 5'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            RESP: begin
                state_d   = IDLE;
                err_oob_d = err_oob_q | oob;
                if (req_q.wstrb != WSTRB_READ) wr_cnt_d = wr_cnt_q + 32'd1;
                else                           rd_cnt_d = rd_cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            if (cur.wstrb != WSTRB_READ) rdata_d = '0;
            else if (oob)                rdata_d = OOB_RDATA;
            else                         rdata_d = ram[word];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_oob_q   <= 1'b0;
            err_abort_q <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_oob_q   <= err_oob_d;
            err_abort_q <= err_abort_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RESP && req_q.wstrb != WSTRB_READ && !oob) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (req_q.wstrb[i]) ram[word][8*i +: 8] <= req_q.wdata[8*i +: 8];
            end
        end
    end

    assign mem.mem_ready = (state_q == RESP);
    assign mem.mem_rdata = rdata_q;
    assign busy          = (state_q != IDLE);
    assign err_oob       = err_oob_q;
    assign err_abort     = err_abort_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench: three responders (LATENCY 0, 1, 4) driven from one linear sequence.
module tb_picorv32_mem_responder;
    logic clk;
    logic resetn;

    logic        v    [3];
    logic        ins  [3];
    logic [31:0] ad   [3];
    logic [31:0] wdat [3];
    logic [3:0]  wst  [3];

    logic [2:0]  rdy, busy, eoob, eabt;
    logic [31:0] rdata [3];
    logic [31:0] rdc   [3];
    logic [31:0] wrc   [3];

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    logic [31:0] rd;
    logic [5:0]  pat;
    logic        seen;

    picorv32_mem_responder_if if0 ();
    picorv32_mem_responder_if if1 ();
    picorv32_mem_responder_if if4 ();

    assign if0.mem_valid = v[0];  assign if0.mem_instr = ins[0];
    assign if0.mem_addr  = ad[0]; assign if0.mem_wdata = wdat[0]; assign if0.mem_wstrb = wst[0];
    assign if1.mem_valid = v[1];  assign if1.mem_instr = ins[1];
    assign if1.mem_addr  = ad[1]; assign if1.mem_wdata = wdat[1]; assign if1.mem_wstrb = wst[1];
    assign if4.mem_valid = v[2];  assign if4.mem_instr = ins[2];
    assign if4.mem_addr  = ad[2]; assign if4.mem_wdata = wdat[2]; assign if4.mem_wstrb = wst[2];
    assign rdy[0] = if0.mem_ready; assign rdata[0] = if0.mem_rdata;
    assign rdy[1] = if1.mem_ready; assign rdata[1] = if1.mem_rdata;
    assign rdy[2] = if4.mem_ready; assign rdata[2] = if4.mem_rdata;

    picorv32_mem_responder #(.DEPTH(1024), .LATENCY(0), .BASE_ADDR(32'h0000_0000),
                             .OOB_RDATA(32'hDEAD_BEEF)) dut0 (
        .clk(clk), .resetn(resetn), .mem(if0), .busy(busy[0]), .err_oob(eoob[0]),
        .err_abort(eabt[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

    picorv32_mem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h1000_0000),
                             .OOB_RDATA(32'hDEAD_BEEF)) dut1 (
        .clk(clk), .resetn(resetn), .mem(if1), .busy(busy[1]), .err_oob(eoob[1]),
        .err_abort(eabt[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

    picorv32_mem_responder #(.DEPTH(1024), .LATENCY(4), .BASE_ADDR(32'h0000_0000),
                             .OOB_RDATA(32'hDEAD_BEEF)) dut4 (
        .clk(clk), .resetn(resetn), .mem(if4), .busy(busy[2]), .err_oob(eoob[2]),
        .err_abort(eabt[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic xact(input int s, input logic instr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output int l, output logic [31:0] r);
        v[s] = 1'b1; ins[s] = instr; ad[s] = a; wdat[s] = wd; wst[s] = ws;
        l = 0;
        while (l < 40) begin
            @(negedge clk);
            l++;
            if (rdy[s]) break;
        end
        r = rdata[s];
        v[s] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; ins[i] = 1'b0; ad[i] = '0; wdat[i] = '0; wst[i] = '0;
        end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(rdy[1]),  32'd0);
        chk("rst_rdata",  rdata[1],     32'd0);
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_errs",   32'({eoob, eabt}), 32'd0);
        chk("rst_rdcnt",  rdc[1],       32'd0);
        chk("rst_wrcnt",  wrc[1],       32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // LATENCY=1 write then read
        xact(1, 1'b0, 32'h1000_0000, 32'h1122_3344, 4'hF, lat, rd);
        chk("l1_wr_lat",   32'(lat), 32'd2);
        chk("l1_wr_rdata", rd,       32'd0);
        xact(1, 1'b0, 32'h1000_0000, 32'h0, 4'h0, lat, rd);
        chk("l1_rd_lat",   32'(lat), 32'd2);
        chk("l1_rd_data",  rd,       32'h1122_3344);
        chk("l1_wrcnt",    wrc[1],   32'd1);
        chk("l1_rdcnt",    rdc[1],   32'd1);

        // LATENCY=0 back-to-back fetches held continuously
        v[0] = 1'b1; ins[0] = 1'b1; wst[0] = 4'h0; ad[0] = 32'h0; pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat[k] = rdy[0];
            if (rdy[0]) ad[0] = ad[0] + 32'd4;
            if (k == 4) v[0] = 1'b0;
        end
        ins[0] = 1'b0;
        chk("b2b_pattern", 32'(pat), 32'h15);
        chk("b2b_rdcnt",   rdc[0],   32'd3);

        // Byte lanes
        xact(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, rd);
        chk("l0_wr_lat", 32'(lat), 32'd1);
        xact(0, 1'b0, 32'h0, 32'hAABB_CCDD, 4'b0100, lat, rd);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd);
        chk("lane_data", rd, 32'h00BB_0000);
        chk("pre_oob",   32'(eoob[0]), 32'd0);

        // Out of range, plus last in-range word
        xact(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, lat, rd);
        chk("oob_rdata", rd, 32'hDEAD_BEEF);
        chk("oob_flag",  32'(eoob[0]), 32'd1);
        xact(0, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, lat, rd);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd);
        chk("oob_wr_noalias", rd, 32'h00BB_0000);
        xact(0, 1'b0, 32'h0000_0FFC, 32'h1234_5678, 4'hF, lat, rd);
        xact(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, lat, rd);
        chk("last_word", rd, 32'h1234_5678);
        chk("l0_wrcnt",  wrc[0], 32'd4);
        chk("l0_rdcnt",  rdc[0], 32'd7);

        // LATENCY=4 write; inputs change during WAIT and must be ignored
        v[2] = 1'b1; ins[2] = 1'b0; ad[2] = 32'h10; wdat[2] = 32'h5555_AAAA; wst[2] = 4'hF;
        @(negedge clk);
        lat = 1;
        ad[2] = 32'h20; wdat[2] = 32'h0; wst[2] = 4'h0;
        while (lat < 40 && !rdy[2]) begin
            @(negedge clk);
            lat++;
        end
        chk("l4_wr_lat", 32'(lat), 32'd5);
        v[2] = 1'b0;
        @(negedge clk);
        xact(2, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
        chk("l4_rd_lat",  32'(lat), 32'd5);
        chk("l4_capture", rd, 32'h5555_AAAA);
        chk("pre_abort",  32'(eabt[2]), 32'd0);

        // Abort two cycles after accept
        v[2] = 1'b1; ad[2] = 32'h10; wst[2] = 4'h0; seen = 1'b0;
        @(negedge clk); seen |= rdy[2];
        @(negedge clk); seen |= rdy[2];
        v[2] = 1'b0;
        @(negedge clk); seen |= rdy[2];
        chk("abort_busy", 32'(busy[2]), 32'd0);
        chk("abort_flag", 32'(eabt[2]), 32'd1);
        repeat (6) begin
            @(negedge clk); seen |= rdy[2];
        end
        chk("abort_noready", 32'(seen), 32'd0);
        chk("abort_rdcnt",   rdc[2],    32'd1);
        chk("abort_wrcnt",   wrc[2],    32'd1);

        // Reset in the middle of WAIT
        v[2] = 1'b1; ad[2] = 32'h10; wst[2] = 4'h0;
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("mrst_ready", 32'(rdy[2]),  32'd0);
        chk("mrst_busy",  32'(busy[2]), 32'd0);
        chk("mrst_rdcnt", rdc[2],       32'd0);
        chk("mrst_wrcnt", wrc[2],       32'd0);
        chk("mrst_l0cnt", rdc[0],       32'd0);
        chk("mrst_flags", 32'({eoob, eabt}), 32'd0);
        v[2] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        xact(2, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
        chk("ram_kept", rd, 32'h5555_AAAA);
        chk("post_rdcnt", rdc[2], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
